// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: sequencer state encoding and counter sizing shared by reset_seq
package reset_seq_pkg;
   typedef enum logic [1:0] {RST, HOLD, REL, RUN} state_t;
   function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
      return $clog2((hold_cycles > gap_cycles ? hold_cycles : gap_cycles) + 1);
   endfunction
endpackage

// File: rtl/reset_sync.sv
// reset_sync: async-assert / sync-deassert reset synchroniser
// ports: clk, rstn_async (async active-low in), rstn_sync (released CYCLES edges after rstn_async rises)
module reset_sync #(
   parameter int CYCLES = 2
) (
   input  logic clk,
   input  logic rstn_async,
   output logic rstn_sync
);
   logic [CYCLES-1:0] chain;
   always_ff @(posedge clk or negedge rstn_async)
      if (!rstn_async) chain <= '0;
      else chain <= {chain[CYCLES-2:0], 1'b1};
   assign rstn_sync = chain[CYCLES-1];
endmodule

// File: rtl/reset_seq.sv
// reset_seq: holds all domains in reset, then releases them one by one in index order
// ports: clk; rstn_async (async active-low); sw_rst_req (1-cycle soft reset request);
//        rstn_out[N_DOMAINS] (active-low per-domain resets, bit 0 first); ready (all domains out of reset)
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int N_DOMAINS   = 3,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                 clk,
   input  logic                 rstn_async,
   input  logic                 sw_rst_req,
   output logic [N_DOMAINS-1:0] rstn_out,
   output logic                 ready
);
   localparam int cw = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam int iw = N_DOMAINS > 1 ? $clog2(N_DOMAINS) : 1;
   // the edge leaving RST already counts as the first hold cycle
   localparam int hold_last = HOLD_CYCLES > 1 ? HOLD_CYCLES - 2 : 0;
   state_t          state;
   logic [cw-1:0]   cnt;
   logic [iw-1:0]   idx;
   logic            rstn_sync;
   logic            start_rel;
   reset_sync #(.CYCLES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rstn_async(rstn_async),
      .rstn_sync (rstn_sync)
   );
   always_comb
      start_rel = HOLD_CYCLES == 1 ? state == RST && rstn_sync
                                   : state == HOLD && cnt == cw'(hold_last);
   // a soft reset re-enters RST for one cycle, so it gets a full HOLD_CYCLES hold
   always_ff @(posedge clk or negedge rstn_async)
      if (!rstn_async) begin
         state    <= RST;
         cnt      <= '0;
         idx      <= '0;
         rstn_out <= '0;
         ready    <= 1'b0;
      end else if (state != RST && sw_rst_req) begin
         state    <= RST;
         cnt      <= '0;
         idx      <= '0;
         rstn_out <= '0;
         ready    <= 1'b0;
      end else if (start_rel) begin
         state    <= N_DOMAINS == 1 ? RUN : REL;
         cnt      <= '0;
         idx      <= iw'(1);
         rstn_out <= N_DOMAINS'(1);
         ready    <= N_DOMAINS == 1;
      end else if (state == RST && rstn_sync) begin
         state <= HOLD;
         cnt   <= '0;
      end else if (state == HOLD) begin
         cnt <= cnt + 1'b1;
      end else if (state == REL && cnt == cw'(GAP_CYCLES - 1)) begin
         cnt      <= '0;
         idx      <= idx + 1'b1;
         rstn_out <= (rstn_out << 1) | N_DOMAINS'(1);
         state    <= idx == iw'(N_DOMAINS - 1) ? RUN : REL;
         ready    <= idx == iw'(N_DOMAINS - 1);
      end else if (state == REL) begin
         cnt <= cnt + 1'b1;
      end
endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: checks reset_seq release timing against an edge-arithmetic model
module tb_reset_seq;
   localparam int N = 3, SYNC = 2, HOLD = 4, GAP = 3;
   localparam int BIG = 1 << 30;
   logic       clk = 1'b0;
   logic       rstn_async;
   logic       sw_rst_req;
   logic       sw1;
   logic [2:0] rstn_out;
   logic       ready;
   logic [0:0] rstn_out1;
   logic       ready1;
   int cyc = 0, e1 = BIG, base = BIG, acc = BIG;
   int n_cmp = 0, n_bad = 0;

   reset_seq #(.N_DOMAINS(N), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rstn_async(rstn_async), .sw_rst_req(sw_rst_req), .rstn_out(rstn_out), .ready(ready));
   reset_seq #(.N_DOMAINS(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(3)) dut1 (
      .clk(clk), .rstn_async(rstn_async), .sw_rst_req(sw1), .rstn_out(rstn_out1), .ready(ready1));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   // model: domain 0 releases at edge base, each further domain GAP edges later
   always @(posedge clk) begin
      cyc++;
      if (rstn_async && sw_rst_req && cyc >= acc) base = cyc + HOLD;
   end

   always @(negedge clk) begin
      int k;
      k = cyc < base ? 0 : 1 + (cyc - base) / GAP;
      if (k > N) k = N;
      check("model_rstn_out", {29'd0, rstn_out}, (32'd1 << k) - 32'd1);
      check("model_ready", {31'd0, ready}, {31'd0, k == N});
      n_cmp++;
      assert ((rstn_out & (rstn_out + 3'd1)) == 3'd0 && ready == &rstn_out && ready1 == rstn_out1[0])
      else begin
         n_bad++;
         $display("FAIL thermo_ready at cycle %0d: rstn_out=%b ready=%b rstn_out1=%b ready1=%b",
                  cyc, rstn_out, ready, rstn_out1, ready1);
      end
   end

   task automatic at(input int r);
      int guard = 0;
      while (cyc < e1 + r - 1 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != e1 + r - 1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL at_edge: cycle %0d expected %0d", cyc, e1 + r - 1);
      end
   endtask

   task automatic pin(input int r, input logic [2:0] v, input string nm);
      at(r);
      check({nm, "_rstn_out"}, {29'd0, rstn_out}, {29'd0, v});
      check({nm, "_ready"}, {31'd0, ready}, {31'd0, v == 3'b111});
   endtask

   task automatic release_rst();
      @(negedge clk);
      rstn_async = 1'b1;
      e1   = cyc + 1;
      base = e1 + SYNC + HOLD - 1;
      acc  = e1 + SYNC + 1;
   endtask

   task automatic assert_rst(input string nm);
      #2 rstn_async = 1'b0;
      base = BIG;
      acc  = BIG;
      e1   = BIG;
      #1;
      check({nm, "_async_out"}, {29'd0, rstn_out}, 32'd0);
      check({nm, "_async_ready"}, {31'd0, ready}, 32'd0);
      check({nm, "_async_out1"}, {30'd0, rstn_out1, ready1}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rstn_async = 1'b0;
      sw_rst_req = 1'b0;
      sw1 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", {29'd0, rstn_out}, 32'd0);
      check("reset_ready", {31'd0, ready}, 32'd0);
      release_rst();
      at(2);
      check("single_e2", {30'd0, rstn_out1, ready1}, 32'd0);
      at(3);
      check("single_e3", {30'd0, rstn_out1, ready1}, 32'd3);
      pin(5, 3'b000, "po_e5");
      pin(6, 3'b001, "po_e6");
      pin(8, 3'b001, "po_e8");
      pin(9, 3'b011, "po_e9");
      pin(11, 3'b011, "po_e11");
      pin(12, 3'b111, "po_e12");
      at(20);
      sw_rst_req = 1'b1;
      at(21);
      sw_rst_req = 1'b0;
      pin(21, 3'b000, "sw_e21");
      pin(24, 3'b000, "sw_e24");
      pin(25, 3'b001, "sw_e25");
      pin(28, 3'b011, "sw_e28");
      pin(30, 3'b011, "sw_e30");
      pin(31, 3'b111, "sw_e31");
      at(33);
      assert_rst("p2");
      repeat (2) @(negedge clk);
      release_rst();
      pin(10, 3'b011, "mid_e10");
      sw_rst_req = 1'b1;
      at(11);
      sw_rst_req = 1'b0;
      pin(11, 3'b000, "mid_e11");
      pin(14, 3'b000, "mid_e14");
      pin(15, 3'b001, "mid_e15");
      pin(18, 3'b011, "mid_e18");
      pin(20, 3'b011, "mid_e20");
      pin(21, 3'b111, "mid_e21");
      at(23);
      assert_rst("p3a");
      repeat (2) @(negedge clk);
      release_rst();
      pin(6, 3'b001, "ar_e6");
      at(7);
      assert_rst("p3");
      repeat (3) @(negedge clk);
      release_rst();
      pin(5, 3'b000, "ar_e5");
      pin(6, 3'b001, "ar_e6b");
      pin(9, 3'b011, "ar_e9");
      pin(12, 3'b111, "ar_e12");
      at(13);
      assert_rst("p4");
      @(negedge clk);
      sw_rst_req = 1'b1;
      @(negedge clk);
      release_rst();
      at(3);
      sw_rst_req = 1'b0;
      pin(5, 3'b000, "ign_e5");
      pin(6, 3'b001, "ign_e6");
      pin(9, 3'b011, "ign_e9");
      pin(12, 3'b111, "ign_e12");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 3: number of sequenced reset outputs (legal range 1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on rstn_async deassertion (minimum 2).
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: minimum cycles all domains stay in reset after the synchronised release (minimum 1).
REQ-004 SHALL have parameter GAP_CYCLES, default 4: cycles between consecutive domain releases (minimum 1).
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port rstn_async, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port sw_rst_req, input, 1: synchronous single-cycle software reset request.
REQ-008 SHALL have port rstn_out, output, N_DOMAINS: per-domain active-low resets; bit 0 releases first.
REQ-009 SHALL have port ready, output, 1: high when every domain is out of reset.

Function
REQ-010 SHALL implement states RST, HOLD, REL and RUN.
- RST: held while the synchronised reset is low.
- HOLD: counting HOLD_CYCLES.
- REL: releasing domains in order.
- RUN: all domains released.
REQ-011 SHALL pass rstn_async through a SYNC_STAGES flop chain, cleared asynchronously, whose output rstn_sync gates exit from RST.
REQ-012 SHALL enter HOLD on the edge where rstn_sync is sampled high and clear the counter on entry.
REQ-013 SHALL drive rstn_out[0] high on clock edge SYNC_STAGES+HOLD_CYCLES, counting the first edge with rstn_async high as edge 1.
REQ-014 SHALL drive rstn_out[i] high exactly GAP_CYCLES edges after rstn_out[i-1], for i = 1..N_DOMAINS-1.
REQ-015 SHALL assert ready and enter RUN on the same edge that rstn_out[N_DOMAINS-1] rises; with N_DOMAINS=1 this is the same edge as REQ-013.
REQ-016 SHALL, when sw_rst_req is high in RUN, drive all rstn_out low and ready low at the next edge, then re-run HOLD and REL; SYNC_STAGES latency does not apply.
REQ-017 SHALL, when sw_rst_req is high in HOLD or REL, drive all rstn_out low at the next edge and restart HOLD from count 0.
REQ-018 SHALL ignore sw_rst_req in RST.
REQ-019 SHALL never release a domain before all lower-index domains are released; rstn_out bits SHALL form a thermometer code at all times.
REQ-020 SHALL size the counter as clog2(max(HOLD_CYCLES,GAP_CYCLES)+1) bits; the counter SHALL never wrap.
REQ-021 SHALL drive every output directly from a flop; outputs SHALL have no combinational path from any input.

Reset
REQ-022 SHALL, on rstn_async low, asynchronously and immediately clear: the sync chain, the counter, the domain index, rstn_out (to all zeros) and ready (to 0), and force state RST.
REQ-023 SHALL deassert all internal and output resets only synchronously to clk.
REQ-024 SHALL, on rstn_async assertion mid-REL or mid-HOLD, abandon the sequence; a subsequent release SHALL restart at REQ-013 timing.

Structure
REQ-025 SHALL place the state enum and the counter-width helper function in shared package reset_seq_pkg.
REQ-026 SHALL instantiate the existing reset_sync module, with CYCLES=SYNC_STAGES, as its single sub-module for the synchroniser chain.

Verification
Bench configuration for REQ-027 to REQ-031: N_DOMAINS=3, SYNC_STAGES=2, HOLD_CYCLES=4, GAP_CYCLES=3.
REQ-027 SHALL cover power-on: rstn_async high before edge 1 -> rstn_out steps to 001 at edge 6, 011 at edge 9 and 111 at edge 12; ready=1 at edge 12.
REQ-028 SHALL cover software reset: sw_rst_req pulsed at edge 20 in RUN -> rstn_out=000 and ready=0 at edge 21; 001 at edge 25, 011 at edge 28, 111 at edge 31.
REQ-029 SHALL cover a request mid-sequence: sw_rst_req at edge 10 (rstn_out=011) -> 000 at edge 11; 001 at edge 15, 111 at edge 21.
REQ-030 SHALL cover async reset mid-sequence: rstn_async low between edges 7 and 8 -> rstn_out=000 and ready=0 with no clock edge; after release, timing matches REQ-027 relative to the new edge 1.
REQ-031 SHALL cover ignored request: sw_rst_req held high during RST -> no effect; power-on timing is identical to REQ-027.
REQ-032 SHALL cover a single domain: N_DOMAINS=1, HOLD_CYCLES=1 -> rstn_out[0]=1 and ready=1 at edge 3.
REQ-033 SHALL check, with continuous assertions: rstn_out is always a thermometer code, and ready equals &rstn_out.
